csr_ctrl: RTL and testbench

Machine-mode CSR controller for the CPU. Accepts CSR instruction requests from the pipeline, sequences each one as a read-modify-write through an internal CSR ALU, and owns the machine CSRs (mstatus, mie, mip, mtvec, mepc, mcause, cycle/instret counters). It also arbitrates interrupt entry and `mret` against CSR instructions and issues PC redirects to fetch.

---
 rtl/csr_pkg.sv | 39 +++
 rtl/csr_alu.sv | 24 ++
 rtl/csr_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_csr_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR controller: CSR addresses,
// funct3 encodings, mstatus/mie bit positions, mcause codes and FSM states.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  localparam logic [2:0] F3_RW  = 3'b001;
  localparam logic [2:0] F3_RS  = 3'b010;
  localparam logic [2:0] F3_RC  = 3'b011;
  localparam logic [2:0] F3_RWI = 3'b101;
  localparam logic [2:0] F3_RSI = 3'b110;
  localparam logic [2:0] F3_RCI = 3'b111;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MTIE     = 7;
  localparam int MIE_MEIE     = 11;

  localparam logic [31:0] MCAUSE_EXT = 32'h8000_000B;
  localparam logic [31:0] MCAUSE_TMR = 32'h8000_0007;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_TRAP,
    S_RET
  } state_t;

endpackage

// File: rtl/csr_alu.sv
// Combinational CSR read-modify-write ALU: new value plus write enable.
module csr_alu
  import csr_pkg::*;
(
  input  logic [31:0] old_val,
  input  logic [31:0] src,
  input  logic [2:0]  funct3,
  input  logic        src_zero,
  output logic [31:0] wdata,
  output logic        we
);

  always_comb begin
    wdata = old_val;
    we    = 1'b0;
    case (funct3)
      F3_RW, F3_RWI: begin wdata = src;              we = 1'b1;      end
      F3_RS, F3_RSI: begin wdata = old_val | src;    we = ~src_zero; end
      F3_RC, F3_RCI: begin wdata = old_val & ~src;   we = ~src_zero; end
      default: ;
    endcase
  end

endmodule

// File: rtl/csr_ctrl.sv
// Machine-mode CSR controller: RMW sequencing, trap entry/mret, PC redirect.
// Define CSR_COUNTER_EN to implement mcycle/minstret (and their high halves).
module csr_ctrl
  import csr_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csr_req_valid,
  output logic        csr_req_ready,
  input  logic [11:0] csr_addr,
  input  logic [2:0]  csr_funct3,
  input  logic [31:0] csr_src,
  input  logic        csr_src_zero,
  output logic        csr_rd_valid,
  output logic [31:0] csr_rd_data,
  input  logic        mret_valid,
  output logic        mret_ready,
  input  logic        irq_ext,
  input  logic        irq_timer,
  input  logic [31:0] irq_pc,
  input  logic        retire,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  state_t      state;
  logic [11:0] r_addr;
  logic [2:0]  r_funct3;
  logic [31:0] r_src;
  logic        r_zero;
  logic        st_mie, st_mpie, ie_mtie, ie_meie, trap_ext;
  logic [31:0] mtvec, mcause;
  logic [31:2] mepc;
  logic [31:0] rd_val, alu_wdata;
  logic        alu_we, irq_pend;
  logic        unused_bits;

  assign irq_pend      = st_mie & ((ie_meie & irq_ext) | (ie_mtie & irq_timer));
  assign csr_req_ready = (state == S_IDLE) & ~irq_pend;
  assign mret_ready    = csr_req_ready & ~csr_req_valid;

`ifdef CSR_COUNTER_EN
  logic [63:0] mcycle, minstret;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      mcycle <= mcycle + 64'd1;
      if (retire) minstret <= minstret + 64'd1;
    end
  end

  assign unused_bits = ^irq_pc[1:0];
`else
  assign unused_bits = ^{irq_pc[1:0], retire};
`endif

  always_comb begin
    rd_val = '0;
    case (r_addr)
      CSR_MSTATUS: begin
        rd_val[MSTATUS_MIE]  = st_mie;
        rd_val[MSTATUS_MPIE] = st_mpie;
      end
      CSR_MIE: begin
        rd_val[MIE_MTIE] = ie_mtie;
        rd_val[MIE_MEIE] = ie_meie;
      end
      CSR_MIP: begin
        rd_val[MIE_MTIE] = irq_timer;
        rd_val[MIE_MEIE] = irq_ext;
      end
      CSR_MTVEC:  rd_val = mtvec;
      CSR_MEPC:   rd_val = {mepc, 2'b00};
      CSR_MCAUSE: rd_val = mcause;
`ifdef CSR_COUNTER_EN
      CSR_MCYCLE:    rd_val = mcycle[31:0];
      CSR_MCYCLEH:   rd_val = mcycle[63:32];
      CSR_MINSTRET:  rd_val = minstret[31:0];
      CSR_MINSTRETH: rd_val = minstret[63:32];
`endif
      default: ;
    endcase
  end

  // Old value is taken from the registered read data, so the RMW sees a stable operand.
  csr_alu u_alu (
    .old_val  (csr_rd_data),
    .src      (r_src),
    .funct3   (r_funct3),
    .src_zero (r_zero),
    .wdata    (alu_wdata),
    .we       (alu_we)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      r_addr         <= '0;
      r_funct3       <= '0;
      r_src          <= '0;
      r_zero         <= 1'b0;
      st_mie         <= 1'b0;
      st_mpie        <= 1'b0;
      ie_mtie        <= 1'b0;
      ie_meie        <= 1'b0;
      trap_ext       <= 1'b0;
      mtvec          <= RESET_MTVEC;
      mepc           <= '0;
      mcause         <= '0;
      csr_rd_valid   <= 1'b0;
      csr_rd_data    <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (irq_pend) begin
            state          <= S_TRAP;
            trap_ext       <= ie_meie & irq_ext;
            redirect_valid <= 1'b1;
            redirect_pc    <= {mtvec[31:2], 2'b00};
          end else if (csr_req_valid) begin
            state    <= S_READ;
            r_addr   <= csr_addr;
            r_funct3 <= csr_funct3;
            r_src    <= csr_src;
            r_zero   <= csr_src_zero;
          end else if (mret_valid) begin
            state          <= S_RET;
            redirect_valid <= 1'b1;
            redirect_pc    <= {mepc, 2'b00};
          end
        end
        S_READ: begin
          csr_rd_data  <= rd_val;
          csr_rd_valid <= 1'b1;
          state        <= S_WRITE;
        end
        S_WRITE: begin
          csr_rd_valid <= 1'b0;
          state        <= S_IDLE;
          if (alu_we) begin
            case (r_addr)
              CSR_MSTATUS: begin
                st_mie  <= alu_wdata[MSTATUS_MIE];
                st_mpie <= alu_wdata[MSTATUS_MPIE];
              end
              CSR_MIE: begin
                ie_mtie <= alu_wdata[MIE_MTIE];
                ie_meie <= alu_wdata[MIE_MEIE];
              end
              CSR_MTVEC:  mtvec  <= alu_wdata;
              CSR_MEPC:   mepc   <= alu_wdata[31:2];
              CSR_MCAUSE: mcause <= alu_wdata;
              default: ;
            endcase
          end
        end
        S_TRAP: begin
          mepc           <= irq_pc[31:2];
          mcause         <= trap_ext ? MCAUSE_EXT : MCAUSE_TMR;
          st_mpie        <= st_mie;
          st_mie         <= 1'b0;
          redirect_valid <= 1'b0;
          redirect_pc    <= '0;
          state          <= S_IDLE;
        end
        S_RET: begin
          st_mie         <= st_mpie;
          st_mpie        <= 1'b1;
          redirect_valid <= 1'b0;
          redirect_pc    <= '0;
          state          <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_ctrl.sv
// Self-checking bench for csr_ctrl: directed sequence plus random CSR traffic
// against a register-level reference model.
module tb_csr_ctrl;

  localparam logic [31:0] RMTVEC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        csr_req_valid = 1'b0;
  logic        csr_req_ready;
  logic [11:0] csr_addr = '0;
  logic [2:0]  csr_funct3 = '0;
  logic [31:0] csr_src = '0;
  logic        csr_src_zero = 1'b0;
  logic        csr_rd_valid;
  logic [31:0] csr_rd_data;
  logic        mret_valid = 1'b0;
  logic        mret_ready;
  logic        irq_ext = 1'b0;
  logic        irq_timer = 1'b0;
  logic [31:0] irq_pc = '0;
  logic        retire = 1'b0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  csr_ctrl #(.RESET_MTVEC(RMTVEC)) dut (
    .clk(clk), .rst_n(rst_n),
    .csr_req_valid(csr_req_valid), .csr_req_ready(csr_req_ready),
    .csr_addr(csr_addr), .csr_funct3(csr_funct3), .csr_src(csr_src),
    .csr_src_zero(csr_src_zero), .csr_rd_valid(csr_rd_valid), .csr_rd_data(csr_rd_data),
    .mret_valid(mret_valid), .mret_ready(mret_ready),
    .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_pc(irq_pc), .retire(retire),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  int total = 0;
  int bad = 0;

  // Reference machine state, kept as full 32-bit architectural values.
  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause;
  logic [63:0] m_cyc, m_ret;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc <= '0;
      m_ret <= '0;
    end else begin
      m_cyc <= m_cyc + 64'd1;
      if (retire) m_ret <= m_ret + 64'd1;
    end
  end

  task automatic model_reset();
    m_mstatus = '0; m_mie = '0; m_mtvec = RMTVEC; m_mepc = '0; m_mcause = '0;
  endtask

  function automatic logic [31:0] ref_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return (32'(irq_ext) << 11) | (32'(irq_timer) << 7);
`ifdef CSR_COUNTER_EN
      12'hB00: return m_cyc[31:0];
      12'hB80: return m_cyc[63:32];
      12'hB02: return m_ret[31:0];
      12'hB82: return m_ret[63:32];
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic ref_write(input logic [11:0] a, input logic [2:0] f3,
                           input logic [31:0] src, input logic zero, input logic [31:0] old);
    logic [31:0] nv;
    case (f3[1:0])
      2'd1: nv = src;
      2'd2: nv = old | src;
      2'd3: nv = old & ~src;
      default: return;
    endcase
    if (f3[1:0] != 2'd1 && zero) return;
    case (a)
      12'h300: m_mstatus = nv & 32'h0000_0088;
      12'h304: m_mie     = nv & 32'h0000_0880;
      12'h305: m_mtvec   = nv;
      12'h341: m_mepc    = nv & ~32'h3;
      12'h342: m_mcause  = nv;
      default: ;
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic csr_op(input logic [11:0] a, input logic [2:0] f3, input logic [31:0] src,
                        input logic zero, output logic [31:0] got);
    logic [31:0] exp;
    bit ok = 1'b0;
    csr_addr = a; csr_funct3 = f3; csr_src = src; csr_src_zero = zero;
    csr_req_valid = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (csr_req_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    got = '0;
    if (!ok) begin
      check("req_ready_timeout", 32'(csr_req_ready), 32'd1);
      csr_req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    csr_req_valid = 1'b0;
    exp = ref_read(a);
    @(negedge clk);
    check("rd_valid_in_read", 32'(csr_rd_valid), 32'd0);
    @(negedge clk);
    check("rd_valid_in_write", 32'(csr_rd_valid), 32'd1);
    check($sformatf("rd_data_%h", a), csr_rd_data, exp);
    got = csr_rd_data;
    ref_write(a, f3, src, zero, exp);
    @(negedge clk);
    check("rd_valid_after", 32'(csr_rd_valid), 32'd0);
  endtask

  task automatic wait_trap(input logic [31:0] exp_pc);
    bit ok = 1'b0;
    bit ext;
    ext = m_mie[11] & irq_ext;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (redirect_valid) begin ok = 1'b1; break; end
    end
    check("trap_redirect_valid", 32'(redirect_valid), 32'd1);
    if (!ok) return;
    check("trap_redirect_pc", redirect_pc, exp_pc);
    m_mepc    = irq_pc & ~32'h3;
    m_mcause  = ext ? 32'h8000_000B : 32'h8000_0007;
    m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
    @(negedge clk);
    check("trap_redirect_drop", {31'b0, redirect_valid}, 32'd0);
  endtask

  task automatic do_mret(input logic [31:0] exp_pc);
    bit ok = 1'b0;
    mret_valid = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (mret_ready) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
    if (!ok) begin
      check("mret_ready_timeout", 32'(mret_ready), 32'd1);
      mret_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    mret_valid = 1'b0;
    @(negedge clk);
    check("mret_redirect_valid", 32'(redirect_valid), 32'd1);
    check("mret_redirect_pc", redirect_pc, exp_pc);
    m_mstatus = (m_mstatus[7] ? 32'h8 : 32'h0) | 32'h80;
    @(negedge clk);
    check("mret_redirect_drop", 32'(redirect_valid), 32'd0);
    check("mret_pc_zero", redirect_pc, 32'd0);
  endtask

  logic [11:0] alist [10] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342,
                              12'h344, 12'hB00, 12'hB82, 12'h123, 12'h7C0};

  initial begin
    logic [31:0] got;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 32'(csr_req_ready), 32'd1);
    check("rst_mret_ready", 32'(mret_ready), 32'd1);
    check("rst_rd_valid", 32'(csr_rd_valid), 32'd0);
    check("rst_rd_data", csr_rd_data, 32'd0);
    check("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);

    // mtvec write returns reset value, then reads back
    csr_op(12'h305, 3'b001, 32'h0000_1003, 1'b0, got);
    check("mtvec_old", got, RMTVEC);
    csr_op(12'h305, 3'b010, 32'h0, 1'b1, got);
    check("mtvec_new", got, 32'h0000_1003);

    // external interrupt entry
    csr_op(12'h304, 3'b001, 32'h0000_0800, 1'b0, got);
    csr_op(12'h300, 3'b010, 32'h0000_0008, 1'b0, got);
    irq_pc = 32'h104; irq_ext = 1'b1;
    wait_trap(32'h0000_1000);
    irq_ext = 1'b0;
    csr_op(12'h342, 3'b010, 32'h0, 1'b1, got); check("mcause_ext", got, 32'h8000_000B);
    csr_op(12'h341, 3'b010, 32'h0, 1'b1, got); check("mepc_trap", got, 32'h104);
    csr_op(12'h300, 3'b010, 32'h0, 1'b1, got); check("mstatus_trap", got, 32'h80);

    // both lines pending: external wins; then mret
    csr_op(12'h304, 3'b010, 32'h0000_0080, 1'b0, got);
    csr_op(12'h300, 3'b010, 32'h0000_0008, 1'b0, got);
    irq_ext = 1'b1; irq_timer = 1'b1;
    wait_trap(32'h0000_1000);
    irq_ext = 1'b0; irq_timer = 1'b0;
    csr_op(12'h342, 3'b010, 32'h0, 1'b1, got); check("mcause_both", got, 32'h8000_000B);
    do_mret(32'h104);
    csr_op(12'h300, 3'b010, 32'h0, 1'b1, got); check("mstatus_mret", got, 32'h88);

    // clear with zero source leaves mstatus untouched
    csr_op(12'h300, 3'b011, 32'hFFFF_FFFF, 1'b1, got); check("rc_zero_old", got, 32'h88);
    csr_op(12'h300, 3'b010, 32'h0, 1'b1, got); check("rc_zero_kept", got, 32'h88);

    // request while interrupt pending: trap first
    csr_op(12'h304, 3'b001, 32'h0000_0800, 1'b0, got);
    irq_pc = 32'h200; irq_ext = 1'b1;
    csr_addr = 12'h300; csr_funct3 = 3'b010; csr_src = '0; csr_src_zero = 1'b1;
    csr_req_valid = 1'b1;
    #1;
    check("pend_req_ready", 32'(csr_req_ready), 32'd0);
    check("pend_mret_ready", 32'(mret_ready), 32'd0);
    wait_trap(32'h0000_1000);
    irq_ext = 1'b0;
    csr_op(12'h300, 3'b010, 32'h0, 1'b1, got); check("req_after_trap", got, 32'h80);

    // csr request beats mret when both valid
    mret_valid = 1'b1;
    csr_addr = 12'h341; csr_funct3 = 3'b010; csr_src = '0; csr_src_zero = 1'b1;
    csr_req_valid = 1'b1;
    #1;
    check("both_mret_ready", 32'(mret_ready), 32'd0);
    check("both_req_ready", 32'(csr_req_ready), 32'd1);
    csr_op(12'h341, 3'b010, 32'h0, 1'b1, got); check("both_mepc", got, 32'h200);
    do_mret(32'h200);

    // mip is read-only; timer-only trap cause
    irq_timer = 1'b1;
    csr_op(12'h344, 3'b001, 32'hFFFF_FFFF, 1'b0, got); check("mip_timer", got, 32'h80);
    csr_op(12'h304, 3'b001, 32'h0000_0080, 1'b0, got);
    wait_trap(32'h0000_1000);
    irq_timer = 1'b0;
    csr_op(12'h342, 3'b010, 32'h0, 1'b1, got); check("mcause_timer", got, 32'h8000_0007);
    csr_op(12'h341, 3'b001, 32'h1234_5677, 1'b0, got);
    csr_op(12'h341, 3'b010, 32'h0, 1'b1, got); check("mepc_align", got, 32'h1234_5674);

    // random traffic, interrupt lines idle
    for (int n = 0; n < 40; n++) begin
      csr_op(alist[$urandom_range(0, 9)], 3'($urandom_range(0, 7)), $urandom,
             1'($urandom_range(0, 1)), got);
    end

    // counters
    rst_n = 1'b0; model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    csr_op(12'hB00, 3'b010, 32'h0, 1'b1, got);
    csr_op(12'hB80, 3'b010, 32'h0, 1'b1, got);
    retire = 1'b1;
    repeat (5) @(negedge clk);
    retire = 1'b0;
    csr_op(12'hB02, 3'b001, 32'h0, 1'b0, got);
`ifdef CSR_COUNTER_EN
    check("minstret_5", got, 32'd5);
`else
    check("minstret_absent", got, 32'd0);
`endif
    csr_op(12'hB82, 3'b010, 32'h0, 1'b1, got);

    // reset during READ abandons the write
    csr_op(12'h300, 3'b010, 32'h8, 1'b0, got);
    csr_addr = 12'h305; csr_funct3 = 3'b001; csr_src = 32'hDEAD_BEEF; csr_src_zero = 1'b0;
    csr_req_valid = 1'b1;
    @(posedge clk); #1;
    csr_req_valid = 1'b0;
    rst_n = 1'b0; model_reset();
    @(negedge clk);
    check("rst_mid_rd_valid", 32'(csr_rd_valid), 32'd0);
    check("rst_mid_rd_data", csr_rd_data, 32'd0);
    @(negedge clk);
    check("rst_mid_rd_valid2", 32'(csr_rd_valid), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    csr_op(12'h305, 3'b010, 32'h0, 1'b1, got); check("rst_mid_mtvec", got, RMTVEC);
    csr_op(12'h300, 3'b010, 32'h0, 1'b1, got); check("rst_mid_mstatus", got, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
